eth_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one 8-bit Ethernet transmit byte stream (o_data/o_tx_en to the MAC/PHY side) between four frame generators: the ARP packet generator and its sibling UDP/ICMP generators. It grants the stream to one requester at a time and forwards that requester's bytes for a whole frame. It enforces the inter-frame gap. Watchdogs revoke the grant from a requester that never starts or never ends its frame.

---
 rtl/eth_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing one 8-bit Ethernet TX byte stream between four frame generators,
// with inter-frame gap enforcement and start/length watchdogs.
module eth_tx_arbiter #(
    parameter int IFG_BYTES = 12,
    parameter int START_TO  = 64,
    parameter int MAX_LEN   = 1530
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  i_req,
    output logic [3:0]  o_gnt,
    input  logic [31:0] i_data,
    input  logic [3:0]  i_tx_en,
    output logic [7:0]  o_data,
    output logic        o_tx_en,
    output logic        o_busy,
    output logic        o_err,
    output logic [1:0]  o_err_id
);

    localparam int WW = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam int IW = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(START_TO - 1);
    localparam logic [IW-1:0] IFG_LAST  = IW'(IFG_BYTES - 1);
    localparam logic [10:0]   LEN_MAX   = 11'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, GRANT_WAIT, XMIT, IFG} state_t;

    state_t          state_reg;
    logic [1:0]      ptr_reg;
    logic [1:0]      g_reg;
    logic [10:0]     byte_cnt_reg;
    logic [WW-1:0]   wait_cnt_reg;
    logic [IW-1:0]   ifg_cnt_reg;

    logic [7:0]      lane [4];
    logic [1:0]      sel;
    logic            sel_valid;
    logic            g_tx_en;
    logic [7:0]      g_byte;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = i_data[8*gi +: 8];
        end
    endgenerate

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (i_req[ptr_reg + 2'(i)]) begin
                sel       = ptr_reg + 2'(i);
                sel_valid = 1'b1;
            end
        end
    end

    assign g_tx_en = i_tx_en[g_reg];
    assign g_byte  = lane[g_reg];
    assign o_busy  = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            g_reg        <= '0;
            byte_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            ifg_cnt_reg  <= '0;
            o_gnt        <= '0;
            o_data       <= '0;
            o_tx_en      <= 1'b0;
            o_err        <= 1'b0;
            o_err_id     <= '0;
        end else begin
            o_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    o_tx_en <= 1'b0;
                    o_data  <= '0;
                    if (sel_valid) begin
                        o_gnt        <= 4'b0001 << sel;
                        g_reg        <= sel;
                        ptr_reg      <= sel + 2'd1;
                        byte_cnt_reg <= '0;
                        wait_cnt_reg <= '0;
                        state_reg    <= GRANT_WAIT;
                    end
                end
                GRANT_WAIT: begin
                    if (g_tx_en) begin
                        o_data       <= g_byte;
                        o_tx_en      <= 1'b1;
                        byte_cnt_reg <= 11'd1;
                        state_reg    <= XMIT;
                    end else if (!i_req[g_reg]) begin
                        o_gnt     <= '0;
                        state_reg <= IDLE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        o_gnt     <= '0;
                        o_err     <= 1'b1;
                        o_err_id  <= g_reg;
                        state_reg <= IDLE;
                    end else if (wait_cnt_reg != '1) begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                XMIT: begin
                    if (!g_tx_en || byte_cnt_reg == LEN_MAX) begin
                        // Either a normal frame end or a length overrun; the rest of an overrun is dropped.
                        o_tx_en     <= 1'b0;
                        o_data      <= '0;
                        o_gnt       <= '0;
                        ifg_cnt_reg <= '0;
                        state_reg   <= IFG;
                        if (g_tx_en) begin
                            o_err    <= 1'b1;
                            o_err_id <= g_reg;
                        end
                    end else begin
                        o_data  <= g_byte;
                        o_tx_en <= 1'b1;
                        if (byte_cnt_reg != '1)
                            byte_cnt_reg <= byte_cnt_reg + 11'd1;
                    end
                end
                IFG: begin
                    o_tx_en <= 1'b0;
                    o_data  <= '0;
                    if (ifg_cnt_reg == IFG_LAST)
                        state_reg <= IDLE;
                    else
                        ifg_cnt_reg <= ifg_cnt_reg + 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed testbench for eth_tx_arbiter: grant order, data forwarding, gap, watchdogs, reset.
module tb_eth_tx_arbiter;

    localparam int IFG_BYTES = 12;
    localparam int START_TO  = 64;
    localparam int MAX_LEN   = 1530;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  i_req;
    logic [3:0]  o_gnt;
    logic [31:0] i_data;
    logic [3:0]  i_tx_en;
    logic [7:0]  o_data;
    logic        o_tx_en;
    logic        o_busy;
    logic        o_err;
    logic [1:0]  o_err_id;

    int checks   = 0;
    int errors   = 0;
    int low_run  = 0;
    int last_gap = 0;
    bit noise    = 1'b0;

    eth_tx_arbiter #(
        .IFG_BYTES(IFG_BYTES),
        .START_TO (START_TO),
        .MAX_LEN  (MAX_LEN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .o_gnt   (o_gnt),
        .i_data  (i_data),
        .i_tx_en (i_tx_en),
        .o_data  (o_data),
        .o_tx_en (o_tx_en),
        .o_busy  (o_busy),
        .o_err   (o_err),
        .o_err_id(o_err_id)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the edge; tracks the run of low o_tx_en samples.
    task automatic step;
        @(posedge clk);
        #1;
        if (o_tx_en === 1'b1) begin
            last_gap = low_run;
            low_run  = 0;
        end else begin
            low_run++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behaves as generator id: waits for its grant, sends len bytes, then drops tx_en.
    task automatic serve(input int id, input int len, input bit check_gap, input bit drop_req);
        int n;
        logic [7:0] b;
        n = 0;
        while (o_gnt == 4'b0000 && n < 200) begin
            step;
            n++;
        end
        chk("grant", o_gnt, 4'b0001 << id);
        if (drop_req) i_req[id] = 1'b0;
        for (int k = 0; k < len; k++) begin
            b = 8'(k * 13 + id * 50 + 1);
            i_data[8*id +: 8] = b;
            i_tx_en[id] = 1'b1;
            if (noise) begin
                for (int j = 0; j < 4; j++) begin
                    if (j != id) begin
                        i_tx_en[j] = 1'($urandom_range(0, 1));
                        i_data[8*j +: 8] = 8'($urandom);
                    end
                end
            end
            step;
            chk("data", {o_tx_en, o_data}, {1'b1, b});
            if (k == 0 && check_gap) chk("gap", last_gap, IFG_BYTES + 2);
        end
        i_tx_en = 4'b0000;
        step;
        chk("frame_end", {o_gnt, o_tx_en}, 5'b0);
        $display("frame id=%0d len=%0d", id, len);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (o_busy && n < 100) begin
            step;
            n++;
            chk("ifg_txen", o_tx_en, 1'b0);
        end
    endtask

    initial begin
        int n;
        int hi, errs, bad;
        logic [1:0] eid;
        bit seen;

        rst_n = 1'b0; i_req = '0; i_tx_en = '0; i_data = '0;
        step; step;
        chk("rst_gnt", o_gnt, 4'b0);
        chk("rst_data", o_data, 8'h0);
        chk("rst_txen", o_tx_en, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_err", o_err, 1'b0);
        chk("rst_errid", o_err_id, 2'd0);
        rst_n = 1'b1;
        step;

        // Single requester, 72-byte frame, with noise on the non-granted lines.
        i_req = 4'b0001;
        step;
        chk("gnt_latency", o_gnt, 4'b0001);
        noise = 1'b1;
        serve(0, 72, 1'b0, 1'b1);
        noise = 1'b0;
        wait_idle(n);
        chk("ifg_busy_len", n, IFG_BYTES);

        // Requesters 0 and 2 from ptr=0: alternate with minimum gap.
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        i_req = 4'b0101;
        serve(0, 20, 1'b0, 1'b0);
        serve(2, 16, 1'b1, 1'b0);
        serve(0, 10, 1'b1, 1'b0);
        serve(2, 8, 1'b1, 1'b0);
        i_req = 4'b0000;
        wait_idle(n);
        chk("ifg_busy_len2", n, IFG_BYTES);

        // Requester 1 never starts; requester 2 pending.
        i_req = 4'b0110;
        step;
        chk("to_gnt", o_gnt, 4'b0010);
        n = 0;
        while (!o_err && n < 200) begin
            step;
            n++;
        end
        $display("start timeout after %0d cycles id=%0d", n, o_err_id);
        chk("to_latency", n, START_TO);
        chk("to_err_id", o_err_id, 2'd1);
        chk("to_gnt_clr", o_gnt, 4'b0);
        i_req[1] = 1'b0;
        step;
        chk("to_err_pulse", o_err, 1'b0);
        chk("to_next_gnt", o_gnt, 4'b0100);
        serve(2, 5, 1'b0, 1'b1);
        wait_idle(n);

        // Requester 3 holds tx_en far past the length limit.
        i_req = 4'b1000;
        step;
        chk("ovr_gnt", o_gnt, 4'b1000);
        i_req = 4'b0000;
        hi = 0; errs = 0; bad = 0; eid = 2'd0; seen = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            i_data[31:24] = 8'(c);
            i_tx_en[3] = 1'b1;
            step;
            if (o_tx_en) begin
                hi++;
                if (seen) bad++;
            end
            if (o_err) begin
                errs++;
                eid  = o_err_id;
                seen = 1'b1;
            end
        end
        i_tx_en = 4'b0000;
        $display("overrun frame bytes=%0d errs=%0d id=%0d", hi, errs, eid);
        chk("ovr_bytes", hi, MAX_LEN);
        chk("ovr_err_cnt", errs, 1);
        chk("ovr_err_id", eid, 2'd3);
        chk("ovr_bus_low", bad, 0);
        chk("ovr_idle", o_busy, 1'b0);

        // Reset mid-frame returns ptr to 0.
        i_req = 4'b0001;
        step;
        chk("mid_gnt", o_gnt, 4'b0001);
        i_req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            i_data[7:0] = 8'(k + 8'h40);
            i_tx_en[0] = 1'b1;
            step;
        end
        chk("mid_txen", o_tx_en, 1'b1);
        rst_n = 1'b0;
        step;
        chk("mid_rst_txen", o_tx_en, 1'b0);
        chk("mid_rst_gnt", o_gnt, 4'b0);
        chk("mid_rst_busy", o_busy, 1'b0);
        rst_n = 1'b1;
        i_tx_en = 4'b0000;
        i_req = 4'b0011;
        step;
        chk("ptr_reset", o_gnt, 4'b0001);
        i_req = 4'b0000;
        step;
        chk("cancel_gnt_err", {o_gnt, o_err}, 5'b0);
        chk("cancel_idle", o_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
